// File: rtl/trojan_resp_collector_if.sv
// trojan_resp_collector_if: vector/response stream from the DUT harness to the collector
interface trojan_resp_collector_if #(parameter int N_IN = 3);
    logic            vec_valid;
    logic [N_IN-1:0] vec_in;
    logic            resp_in;
    modport master (output vec_valid, vec_in, resp_in);
    modport slave  (input  vec_valid, vec_in, resp_in);
endinterface

// File: rtl/trojan_resp_collector.sv
// trojan_resp_collector: captures a truth table from an in-order exhaustive sweep and checks it against GOLDEN
// Optional MISR response signature enabled by defining RESP_MISR_EN; otherwise o_sig_out is 0.
module trojan_resp_collector #(
    parameter int                   N_IN      = 3,
    parameter logic [2**N_IN-1:0]   GOLDEN    = '0,
    parameter int                   SIG_W     = 16,
    parameter logic [SIG_W-1:0]     MISR_POLY = 16'h1021
) (
    input  logic                 i_ck,
    input  logic                 i_reset,
    input  logic                 i_start,
    trojan_resp_collector_if.slave s_if,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_pass,
    output logic [N_IN:0]        o_mism_cnt,
    output logic                 o_fail_valid,
    output logic [N_IN-1:0]      o_first_fail,
    output logic                 o_seq_err,
    output logic [2**N_IN-1:0]   o_resp_map,
    output logic [SIG_W-1:0]     o_sig_out
);
    typedef enum logic [1:0] {IDLE, COLLECT, DONE, ERR} state_t;
    localparam logic [N_IN-1:0] LAST = '1;
    state_t             r_state, w_next;
    logic [N_IN-1:0]    r_exp_idx;
    logic               w_in_col, w_accept, w_bad, w_last, w_mis;
    assign w_in_col = r_state == COLLECT && s_if.vec_valid && !i_start;
    assign w_accept = w_in_col && s_if.vec_in == r_exp_idx;
    assign w_bad    = w_in_col && s_if.vec_in != r_exp_idx;
    assign w_last   = r_exp_idx == LAST;
    assign w_mis    = s_if.resp_in != GOLDEN[r_exp_idx];
    always_comb begin
        w_next = r_state;
        if (i_start)
            w_next = COLLECT;
        else if (w_bad)
            w_next = ERR;
        else if (w_accept && w_last)
            w_next = DONE;
        o_busy = r_state == COLLECT;
        o_done = r_state == DONE;
        o_pass = o_done && o_mism_cnt == '0 && !o_seq_err;
    end
    always_ff @(posedge i_ck) begin
        if (i_reset || i_start) begin
            r_state      <= i_reset ? IDLE : w_next;
            r_exp_idx    <= '0;
            o_mism_cnt   <= '0;
            o_fail_valid <= 1'b0;
            o_first_fail <= '0;
            o_seq_err    <= 1'b0;
            o_resp_map   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                o_resp_map[r_exp_idx] <= s_if.resp_in;
                if (w_mis) begin
                    o_mism_cnt <= o_mism_cnt + 1'b1;
                    if (!o_fail_valid) begin
                        o_first_fail <= r_exp_idx;
                        o_fail_valid <= 1'b1;
                    end
                end
                // hold the index on the final vector so it never wraps
                if (!w_last)
                    r_exp_idx <= r_exp_idx + 1'b1;
            end else if (w_bad) begin
                o_seq_err <= 1'b1;
            end
        end
    end
`ifdef RESP_MISR_EN
    logic [SIG_W-1:0] r_sig;
    always_ff @(posedge i_ck) begin
        if (i_reset || i_start)
            r_sig <= '1;
        else if (w_accept)
            r_sig <= {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? MISR_POLY : '0) ^ {{SIG_W-1{1'b0}}, s_if.resp_in};
    end
    assign o_sig_out = r_sig;
`else
    assign o_sig_out = MISR_POLY & '0;
`endif
endmodule

// File: tb/tb_trojan_resp_collector.sv
// tb_trojan_resp_collector: table-driven sweeps plus directed corner-case sequences
module tb_trojan_resp_collector;
`ifdef RESP_MISR_EN
    localparam bit MISR_ON = 1'b1;
`else
    localparam bit MISR_ON = 1'b0;
`endif
    logic        ck = 1'b0, reset = 1'b0, start = 1'b0;
    logic        busy, done, pass, fail_valid, seq_err;
    logic [3:0]  mism_cnt;
    logic [2:0]  first_fail;
    logic [7:0]  resp_map;
    logic [15:0] sig_out;
    int          n_tests = 0, n_fail = 0;
    trojan_resp_collector_if #(.N_IN(3)) vif ();
    trojan_resp_collector #(.N_IN(3), .GOLDEN(8'h00), .SIG_W(16), .MISR_POLY(16'h1021)) dut (
        .i_ck(ck), .i_reset(reset), .i_start(start), .s_if(vif),
        .o_busy(busy), .o_done(done), .o_pass(pass), .o_mism_cnt(mism_cnt),
        .o_fail_valid(fail_valid), .o_first_fail(first_fail), .o_seq_err(seq_err),
        .o_resp_map(resp_map), .o_sig_out(sig_out)
    );
    always #5 ck = ~ck;
    typedef struct {
        logic [7:0] resp;
        logic [3:0] mism;
        logic [2:0] ff;
        logic       fv;
        logic       pass;
    } sweep_t;
    sweep_t tbl[4];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge ck);
        #1;
    endtask
    task automatic send(input logic [2:0] v, input logic r, input bit gap);
        vif.vec_valid = 1'b1;
        vif.vec_in    = v;
        vif.resp_in   = r;
        step();
        vif.vec_valid = 1'b0;
        if (gap) step();
    endtask
    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask
    task automatic chk_idle_zero(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " pass"}, pass, 0);
        chk({tag, " mism"}, mism_cnt, 0);
        chk({tag, " fv"}, fail_valid, 0);
        chk({tag, " ff"}, first_fail, 0);
        chk({tag, " seq"}, seq_err, 0);
        chk({tag, " map"}, resp_map, 0);
        chk({tag, " sig"}, sig_out, MISR_ON ? 32'hFFFF : 32'h0);
    endtask
    function automatic logic [15:0] misr(input logic [15:0] s, input logic r);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0) ^ {15'b0, r};
    endfunction
    initial begin
        logic [15:0] sig_ref;
        tbl[0] = '{resp: 8'h00, mism: 4'd0, ff: 3'd0, fv: 1'b0, pass: 1'b1};
        tbl[1] = '{resp: 8'h48, mism: 4'd2, ff: 3'd3, fv: 1'b1, pass: 1'b0};
        tbl[2] = '{resp: 8'hFF, mism: 4'd8, ff: 3'd0, fv: 1'b1, pass: 1'b0};
        tbl[3] = '{resp: 8'h80, mism: 4'd1, ff: 3'd7, fv: 1'b1, pass: 1'b0};
        vif.vec_valid = 1'b0;
        vif.vec_in    = '0;
        vif.resp_in   = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk_idle_zero("reset");
        for (int t = 0; t < 4; t++) begin
            pulse_start();
            chk($sformatf("t%0d busy", t), busy, 1);
            for (int k = 0; k < 8; k++) begin
                send(3'(k), tbl[t].resp[k], 1'b0);
                if (k == 6) chk($sformatf("t%0d early done", t), done, 0);
            end
            chk($sformatf("t%0d done", t), done, 1);
            chk($sformatf("t%0d busy off", t), busy, 0);
            chk($sformatf("t%0d pass", t), pass, tbl[t].pass);
            chk($sformatf("t%0d mism", t), mism_cnt, tbl[t].mism);
            chk($sformatf("t%0d fv", t), fail_valid, tbl[t].fv);
            chk($sformatf("t%0d ff", t), first_fail, tbl[t].ff);
            chk($sformatf("t%0d map", t), resp_map, tbl[t].resp);
        end
        pulse_start();
        send(3'd0, 1'b1, 1'b0);
        send(3'd1, 1'b1, 1'b0);
        send(3'd3, 1'b1, 1'b0);
        chk("order seq_err", seq_err, 1);
        chk("order busy", busy, 0);
        chk("order done", done, 0);
        chk("order pass", pass, 0);
        chk("order map", resp_map, 8'h03);
        send(3'd2, 1'b1, 1'b0);
        chk("err ignores map", resp_map, 8'h03);
        pulse_start();
        for (int k = 0; k < 5; k++) send(3'(k), k == 2, 1'b0);
        chk("pre-restart mism", mism_cnt, 1);
        vif.vec_valid = 1'b1;
        vif.vec_in    = 3'd5;
        vif.resp_in   = 1'b1;
        pulse_start();
        vif.vec_valid = 1'b0;
        chk("restart mism", mism_cnt, 0);
        chk("restart map", resp_map, 0);
        chk("restart fv", fail_valid, 0);
        chk("restart busy", busy, 1);
        for (int k = 0; k < 8; k++) send(3'(k), 1'b0, 1'b1);
        chk("gapped pass", pass, 1);
        send(3'd0, 1'b1, 1'b0);
        chk("done ignores map", resp_map, 0);
        chk("done ignores mism", mism_cnt, 0);
        chk("done holds pass", pass, 1);
        pulse_start();
        for (int k = 0; k < 5; k++) send(3'(k), 1'b1, 1'b0);
        chk("pre-reset map", resp_map, 8'h1F);
        vif.vec_valid = 1'b1;
        vif.vec_in    = 3'd5;
        vif.resp_in   = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        vif.vec_valid = 1'b0;
        chk_idle_zero("midreset");
        send(3'd0, 1'b1, 1'b0);
        chk("idle ignores map", resp_map, 0);
        chk("idle ignores mism", mism_cnt, 0);
        chk("idle busy", busy, 0);
        pulse_start();
        sig_ref = 16'hFFFF;
        for (int k = 0; k < 8; k++) begin
            send(3'(k), 1'b0, 1'b0);
            sig_ref = misr(sig_ref, 1'b0);
        end
        chk("misr sig", sig_out, MISR_ON ? {16'h0, sig_ref} : 32'h0);
        send(3'd0, 1'b1, 1'b0);
        chk("misr frozen", sig_out, MISR_ON ? {16'h0, sig_ref} : 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
